// File: rtl/dram_pkg.sv
// Shared types and default widths for the image DRAM responder and its MAR/MDR peers.
package dram_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      RESP    = 2'd3
   } state_t;

endpackage

// File: rtl/dram_bank.sv
// Single-port synchronous RAM with registered read; no reset so it maps to block RAM.
module dram_bank #(
   parameter int DEPTH  = 65536,
   parameter int DATA_W = 8,
   parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      q <= mem[addr];
   end

endmodule

// File: rtl/dram_responder.sv
// Memory-side responder: accepts single-word read/write commands, applies fixed
// latencies and signals completion with a busy/done handshake.
module dram_responder
   import dram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 65536,
   parameter int RD_LAT = 2,
   parameter int WR_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              read,
   input  logic              write,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              done,
   output logic              addr_err
);

   localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT) + 1;
   localparam int BANK_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t              state, state_next;
   logic [CNT_W-1:0]    cnt_q, cnt_next;
   logic [BANK_AW-1:0]  addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                err_q;
   logic                rd_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   bank_q;
   logic [DATA_W-1:0]   rd_word;
   logic                range_err;
   logic                accept;
   logic                bank_we;

   generate
      if (DEPTH < 2**ADDR_W) begin : g_range
         assign range_err = (addr >= ADDR_W'(DEPTH));
      end else begin : g_full
         assign range_err = 1'b0;
      end
   endgenerate

   // RESP already reports busy=0, so it accepts a new request just like IDLE.
   assign accept = ((state == IDLE) || (state == RESP)) && (read || write);

   always_comb begin
      state_next = state;
      cnt_next   = cnt_q;
      case (state)
         IDLE, RESP: begin
            state_next = IDLE;
            if (write) begin
               state_next = WR_WAIT;
               cnt_next   = CNT_W'(WR_LAT - 1);
            end else if (read) begin
               state_next = RD_WAIT;
               cnt_next   = CNT_W'(RD_LAT - 1);
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (cnt_q == '0) state_next = RESP;
            else             cnt_next   = cnt_q - 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_next;
         cnt_q <= cnt_next;
         if (state == RESP && rd_q) rdata_q <= rd_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         addr_q  <= addr[BANK_AW-1:0];
         wdata_q <= wdata;
         err_q   <= range_err;
         rd_q    <= !write;
      end
   end

   // Commit on the last wait cycle so the word is in RAM when done rises.
   assign bank_we = (state == WR_WAIT) && (cnt_q == '0) && !err_q && !rst;

   dram_bank #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .AW     (BANK_AW)
   ) u_bank (
      .clk   (clk),
      .we    (bank_we),
      .addr  (addr_q),
      .wdata (wdata_q),
      .q     (bank_q)
   );

   // Bank output is registered on entry to RESP; present it directly that cycle.
   assign rd_word  = err_q ? '0 : bank_q;
   assign rdata    = (state == RESP && rd_q) ? rd_word : rdata_q;
   assign busy     = (state == RD_WAIT) || (state == WR_WAIT);
   assign done     = (state == RESP);
   assign addr_err = (state == RESP) && err_q;

endmodule

// File: tb/tb_dram_responder.sv
// Scoreboard bench for dram_responder: expectations queued at issue, checked on done.
module tb_dram_responder;

   localparam int RD_LAT = 2;
   localparam int WR_LAT = 1;
   localparam int DEPTH  = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        read, write;
   logic [15:0] addr;
   logic [7:0]  wdata, rdata;
   logic        busy, done, addr_err;

   always #5 clk = ~clk;

   dram_responder #(
      .ADDR_W (16),
      .DATA_W (8),
      .DEPTH  (DEPTH),
      .RD_LAT (RD_LAT),
      .WR_LAT (WR_LAT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .read     (read),
      .write    (write),
      .wdata    (wdata),
      .rdata    (rdata),
      .busy     (busy),
      .done     (done),
      .addr_err (addr_err)
   );

   typedef struct {
      bit         is_rd;
      bit         chk;
      logic [7:0] data;
      bit         err;
      int         acc;
   } exp_t;

   exp_t       sb[$];
   exp_t       got_e;
   logic [7:0] mem_m [256];
   bit         known [256];
   logic [7:0] last_rd = 8'h00;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         n_done = 0;
   int         n_acc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && done) begin
         n_done++;
         if (sb.size() == 0) begin
            check("spurious_done", 32'(done), 32'd0);
         end else begin
            got_e = sb.pop_front();
            check("addr_err", 32'(addr_err), 32'(got_e.err));
            // posedges from the accepting edge to the edge that samples done
            check("latency", 32'(cyc + 1 - got_e.acc), 32'((got_e.is_rd ? RD_LAT : WR_LAT) + 1));
            if (got_e.is_rd) begin
               if (got_e.chk) check("rdata", 32'(rdata), 32'(got_e.data));
               last_rd = rdata;
            end else begin
               check("rdata_hold", 32'(rdata), 32'(last_rd));
            end
         end
      end else if (!rst) begin
         check("err_without_done", 32'(addr_err), 32'd0);
      end
   end

   // Called at a negedge with busy=0; returns at the negedge where done is seen.
   task automatic access(input bit r, input bit w, input logic [15:0] a,
                         input logic [7:0] d, input bit poke);
      exp_t e;
      e.acc   = cyc + 1;
      e.err   = (a >= DEPTH);
      e.is_rd = !w;
      e.chk   = 1'b0;
      e.data  = 8'h00;
      if (w) begin
         if (!e.err) begin
            mem_m[a[7:0]] = d;
            known[a[7:0]] = 1'b1;
         end
      end else begin
         e.chk  = e.err || known[a[7:0]];
         e.data = e.err ? 8'h00 : mem_m[a[7:0]];
      end
      sb.push_back(e);
      n_acc++;
      read = r; write = w; addr = a; wdata = d;
      @(negedge clk);
      read = 1'b0; write = 1'b0;
      check("busy_after_accept", 32'(busy), 32'd1);
      if (poke) begin
         read = 1'b1; write = 1'b1; addr = 16'h0041; wdata = 8'h77;
         @(negedge clk);
         read = 1'b0; write = 1'b0;
      end
      for (int i = 0; i < 16 && !done; i++) @(negedge clk);
      if (!done) check("done_timeout", 32'(done), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; read = 1'b0; write = 1'b0; addr = '0; wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_addr_err", 32'(addr_err), 32'd0);
      rst = 1'b0;

      // read of uninitialised word: timing only
      access(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);

      // write then back-to-back read of same address
      access(1'b0, 1'b1, 16'h0010, 8'hA5, 1'b0);
      access(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0);

      // read & write together: write wins
      access(1'b1, 1'b1, 16'h0020, 8'h3C, 1'b0);
      @(negedge clk);
      access(1'b1, 1'b0, 16'h0020, 8'h00, 1'b0);

      // requests pulsed while busy are ignored
      access(1'b0, 1'b1, 16'h0040, 8'h11, 1'b0);
      access(1'b0, 1'b1, 16'h0041, 8'h22, 1'b0);
      access(1'b1, 1'b0, 16'h0040, 8'h00, 1'b1);
      repeat (3) @(negedge clk);
      access(1'b1, 1'b0, 16'h0041, 8'h00, 1'b0);

      // address range boundary
      access(1'b0, 1'b1, 16'h0000, 8'h99, 1'b0);
      access(1'b0, 1'b1, 16'h00FF, 8'h5A, 1'b0);
      access(1'b1, 1'b0, 16'h00FF, 8'h00, 1'b0);
      access(1'b1, 1'b0, 16'h0100, 8'h00, 1'b0);
      access(1'b0, 1'b1, 16'h0100, 8'hEE, 1'b0);
      access(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);

      // reset during a read wait
      @(negedge clk);
      read = 1'b1; addr = 16'h0010;
      @(negedge clk);
      read = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_rd_busy", 32'(busy), 32'd0);
      check("abort_rd_done", 32'(done), 32'd0);
      check("abort_rd_rdata", 32'(rdata), 32'd0);
      last_rd = 8'h00;
      @(negedge clk);
      check("abort_rd_no_done", 32'(done), 32'd0);

      // reset during a write wait: old value retained
      access(1'b0, 1'b1, 16'h0030, 8'h55, 1'b0);
      @(negedge clk);
      write = 1'b1; addr = 16'h0030; wdata = 8'hAA;
      @(negedge clk);
      write = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_wr_busy", 32'(busy), 32'd0);
      check("abort_wr_done", 32'(done), 32'd0);
      last_rd = 8'h00;
      @(negedge clk);
      access(1'b1, 1'b0, 16'h0030, 8'h00, 1'b0);

      repeat (4) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      check("done_count", 32'(n_done), 32'(n_acc));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
